// File: rtl/fpu_f2i.sv
// Custom-float (sign, 6-bit exponent bias 31, 25-bit mantissa) to signed 32-bit integer converter.
// Multi-cycle: start/ready handshake in, one-cycle done pulse out, 1-bit-per-cycle shifter.
//
// state  | meaning
// IDLE   | ready for a new operand; ready_out high
// DECODE | classify operand, preset special results or load the shifter
// SHIFT  | shift accumulator one bit per cycle until cnt reaches zero
// FINISH | apply sign, publish data/status, pulse done_out
module fpu_f2i #(
  parameter int EXP_W  = 6,
  parameter int MANT_W = 25,
  parameter int BIAS   = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_in,
  input  logic [31:0] op_in,
  output logic        ready_out,
  output logic [31:0] data_out,
  output logic [3:0]  status_out,
  output logic        done_out
);

  localparam int CNT_W   = 5;
  localparam int E_ALIGN = MANT_W;
  localparam int E_SAT   = 31;

  localparam logic [3:0] ST_EXACT   = 4'b0001;
  localparam logic [3:0] ST_OVER    = 4'b0011;
  localparam logic [3:0] ST_UNDER   = 4'b0111;
  localparam logic [3:0] ST_INEXACT = 4'b1111;

  typedef enum logic [1:0] {IDLE, DECODE, SHIFT, FINISH} state_t;

  state_t             state;
  logic [31:0]        op_r;
  logic [31:0]        acc;
  logic [CNT_W-1:0]   cnt;
  logic               dir_left;
  logic               sticky;
  logic               negate;
  logic [3:0]         stat_r;

  logic               op_sign;
  logic [EXP_W-1:0]   op_exp;
  logic [MANT_W-1:0]  op_mant;
  logic [31:0]        sig;
  int                 e_val;

  assign op_sign   = op_r[31];
  assign op_exp    = op_r[MANT_W+EXP_W-1:MANT_W];
  assign op_mant   = op_r[MANT_W-1:0];
  assign sig       = 32'({1'b1, op_mant});
  assign e_val     = int'(op_exp) - BIAS;
  assign ready_out = (state == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op_r       <= '0;
      acc        <= '0;
      cnt        <= '0;
      dir_left   <= 1'b0;
      sticky     <= 1'b0;
      negate     <= 1'b0;
      stat_r     <= '0;
      data_out   <= '0;
      status_out <= ST_EXACT;
      done_out   <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            op_r  <= op_in;
            state <= DECODE;
          end
        end

        DECODE: begin
          sticky   <= 1'b0;
          negate   <= 1'b0;
          dir_left <= 1'b0;
          stat_r   <= ST_EXACT;
          acc      <= '0;
          cnt      <= '0;
          state    <= FINISH;
          if (op_exp == '0 && op_mant == '0) begin
            acc <= '0;
          end else if (e_val < 0) begin
            stat_r <= ST_UNDER;
          end else if (e_val >= E_SAT) begin
            // -2^31 is the one magnitude at e=31 that still fits
            if (op_sign && op_mant == '0 && e_val == E_SAT) begin
              acc <= 32'h8000_0000;
            end else begin
              acc    <= op_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
              stat_r <= ST_OVER;
            end
          end else begin
            acc    <= sig;
            negate <= op_sign;
            if (e_val < E_ALIGN) begin
              cnt   <= CNT_W'(E_ALIGN - e_val);
              state <= SHIFT;
            end else if (e_val > E_ALIGN) begin
              dir_left <= 1'b1;
              cnt      <= CNT_W'(e_val - E_ALIGN);
              state    <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (dir_left) begin
            acc <= acc << 1;
          end else begin
            acc    <= acc >> 1;
            sticky <= sticky | acc[0];
          end
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FINISH;
        end

        FINISH: begin
          data_out   <= negate ? -acc : acc;
          status_out <= sticky ? ST_INEXACT : stat_r;
          done_out   <= 1'b1;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_f2i.sv
// Self-checking bench for fpu_f2i: arithmetic reference model with a per-cycle scoreboard,
// directed vectors, handshake corner cases and a mid-conversion reset.
module tb_fpu_f2i;

  logic        clock;
  logic        reset;
  logic        start_in;
  logic [31:0] op_in;
  logic        ready_out;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        done_out;

  fpu_f2i dut (
    .clock      (clock),
    .reset      (reset),
    .start_in   (start_in),
    .op_in      (op_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .status_out (status_out),
    .done_out   (done_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] op;
    logic [31:0] d;
    logic [3:0]  s;
    int          lat;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[15];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_done = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: value = sig * 2^(e-25), truncated toward zero, then range-checked.
  function automatic void model(input logic [31:0] op, output logic [31:0] d,
                                output logic [3:0] s, output int lat);
    int     e;
    longint sig, mag, val, max_pos, min_neg;
    bit     inexact;
    e       = int'(op[30:25]) - 31;
    sig     = longint'({1'b1, op[24:0]});
    max_pos = (longint'(1) <<< 31) - 1;
    min_neg = -(longint'(1) <<< 31);
    lat     = 2;
    d       = '0;
    s       = 4'b0001;
    if (op[30:0] == 31'd0) begin
      d = '0;
      s = 4'b0001;
    end else if (e < 0) begin
      d = '0;
      s = 4'b0111;
    end else begin
      if (e >= 25) begin
        mag     = sig <<< (e - 25);
        inexact = 1'b0;
      end else begin
        mag     = sig >> (25 - e);
        inexact = ((mag << (25 - e)) != sig);
      end
      val = op[31] ? -mag : mag;
      if (val > max_pos) begin
        d = 32'h7FFF_FFFF;
        s = 4'b0011;
      end else if (val < min_neg) begin
        d = 32'h8000_0000;
        s = 4'b0011;
      end else begin
        d = val[31:0];
        s = inexact ? 4'b1111 : 4'b0001;
      end
      if (e <= 30) lat = 2 + ((e > 25) ? (e - 25) : (25 - e));
    end
  endfunction

  logic [31:0] m_d;
  logic [3:0]  m_s;
  int          m_lat;
  exp_t        m_e;

  // Scoreboard: ready is expected exactly when no conversion is outstanding.
  always @(negedge clock) begin
    cyc++;
    if (reset && chk_en) begin
      if (done_out) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {31'd0, done_out}, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          chk("sb_data", data_out, m_e.d);
          chk("sb_status", {28'd0, status_out}, {28'd0, m_e.s});
          chk("sb_latency", cyc, m_e.due);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        chk("done_late", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      chk("sb_ready", {31'd0, ready_out}, {31'd0, exp_q.size() == 0});
      if (start_in && exp_q.size() == 0) begin
        model(op_in, m_d, m_s, m_lat);
        m_e.d   = m_d;
        m_e.s   = m_s;
        m_e.due = cyc + m_lat + 1;
        exp_q.push_back(m_e);
      end
    end
  end

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 40; i++) begin
      if (n_done >= target) break;
      @(negedge clock);
      #1;
    end
    chk(name, n_done, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pd;
    logic [3:0]  ps;
    int          pl;
    int          n0;

    tbl = '{
      '{32'h3E00_0000, 32'h0000_0001, 4'b0001, 27},
      '{32'hBE00_0000, 32'hFFFF_FFFF, 4'b0001, 27},
      '{32'h4080_0000, 32'h0000_0002, 4'b1111, 26},
      '{32'hC080_0000, 32'hFFFF_FFFE, 4'b1111, 26},
      '{32'h7A00_0000, 32'h4000_0000, 4'b0001, 7},
      '{32'h7000_0000, 32'h0200_0000, 4'b0001, 2},
      '{32'h7C00_0000, 32'h7FFF_FFFF, 4'b0011, 2},
      '{32'hFC00_0000, 32'h8000_0000, 4'b0001, 2},
      '{32'h7E00_0000, 32'h7FFF_FFFF, 4'b0011, 2},
      '{32'hFE00_0000, 32'h8000_0000, 4'b0011, 2},
      '{32'h3C00_0000, 32'h0000_0000, 4'b0111, 2},
      '{32'h0000_0000, 32'h0000_0000, 4'b0001, 2},
      '{32'h8000_0000, 32'h0000_0000, 4'b0001, 2},
      '{32'h0000_0001, 32'h0000_0000, 4'b0111, 2},
      '{32'h3E00_0001, 32'h0000_0001, 4'b1111, 27}
    };

    reset    = 1'b0;
    start_in = 1'b0;
    op_in    = '0;
    #12;
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_done", {31'd0, done_out}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_status", {28'd0, status_out}, 32'd1);

    foreach (tbl[i]) begin
      model(tbl[i].op, pd, ps, pl);
      chk("model_data", pd, tbl[i].d);
      chk("model_status", {28'd0, ps}, {28'd0, tbl[i].s});
      chk("model_lat", pl, tbl[i].lat);
    end

    @(negedge clock);
    reset  = 1'b1;
    chk_en = 1'b1;

    foreach (tbl[i]) begin
      n0 = n_done;
      @(posedge clock); #1;
      op_in    = tbl[i].op;
      start_in = 1'b1;
      @(posedge clock); #1;
      start_in = 1'b0;
      wait_done(n0 + 1, "vec_done");
      chk("vec_data", data_out, tbl[i].d);
      chk("vec_status", {28'd0, status_out}, {28'd0, tbl[i].s});
    end

    // A start while busy must be dropped.
    n0 = n_done;
    @(posedge clock); #1;
    op_in    = 32'h3E00_0000;
    start_in = 1'b1;
    @(posedge clock); #1;
    start_in = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    op_in    = 32'h4080_0000;
    start_in = 1'b1;
    @(posedge clock); #1;
    start_in = 1'b0;
    wait_done(n0 + 1, "busy_done");
    chk("busy_data", data_out, 32'h0000_0001);
    repeat (35) @(negedge clock);
    #1;
    chk("busy_single_result", n_done, n0 + 1);

    // start held across done launches the next conversion immediately.
    n0 = n_done;
    @(posedge clock); #1;
    op_in    = 32'h7C00_0000;
    start_in = 1'b1;
    @(posedge clock); #1;
    op_in    = 32'h7A00_0000;
    wait_done(n0 + 1, "held_first_done");
    chk("held_first_data", data_out, 32'h7FFF_FFFF);
    @(posedge clock); #1;
    start_in = 1'b0;
    wait_done(n0 + 2, "held_second_done");
    chk("held_second_data", data_out, 32'h4000_0000);
    chk("held_second_status", {28'd0, status_out}, 32'd1);

    // Reset in the middle of a SHIFT phase aborts the conversion.
    n0 = n_done;
    @(posedge clock); #1;
    op_in    = 32'h3E00_0000;
    start_in = 1'b1;
    @(posedge clock); #1;
    start_in = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready_out}, 32'd1);
    chk("abort_data", data_out, 32'd0);
    chk("abort_status", {28'd0, status_out}, 32'd1);
    chk("abort_done", {31'd0, done_out}, 32'd0);
    exp_q.delete();
    @(negedge clock);
    @(posedge clock); #3;
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (35) @(negedge clock);
    #1;
    chk("abort_no_done", n_done, n0);
    chk("abort_idle_ready", {31'd0, ready_out}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_f2i.md
Name: fpu_f2i

Overview:
- Converts a 32-bit operand in the FPU custom float format to a signed 32-bit two's-complement integer.
- Format: [31] sign, [30:25] exponent (bias 31), [24:0] mantissa with an implicit leading 1. Exponent field 0 with mantissa 0 encodes zero.
- Sits downstream of the FPU adder and hands its results to integer datapaths.
- Multi-cycle: a start/ready handshake on input, a one-cycle done pulse on output, and a 1-bit-per-cycle shifter.

Parameters:
- EXP_W, 6: exponent field width.
- MANT_W, 25: mantissa field width.
- BIAS, 31: exponent bias.
- Only the defaults are verified.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start_in  input  1  request a conversion of op_in
- op_in  input  32  custom-format float operand
- ready_out  output  1  high only in IDLE; a conversion is accepted when start_in && ready_out at a clock edge
- data_out  output  32  signed integer result; holds until the next completion
- status_out  output  4  0001 exact, 0011 overflow, 0111 underflow, 1111 inexact; holds until the next completion
- done_out  output  1  one-cycle pulse; data_out and status_out are valid in that cycle

Behaviour:
- Reset (async, active-low) values:
  - state IDLE, ready_out 1, done_out 0.
  - data_out 0, status_out 0001.
  - All internal registers 0.
- Reset asserted mid-operation aborts the conversion: no done pulse, outputs take their reset values.
- Definitions: e = exp_field - 31 (signed, range -31..32); sig = {1, mant}, 26 bits; value = sig * 2^(e-25).
- FSM states: IDLE, DECODE, SHIFT, FINISH.
- IDLE:
  - On an edge with start_in=1, register op_in and go to DECODE.
  - start_in is ignored in every other state; ready_out=0 outside IDLE.
- DECODE (one edge): classify, then go to FINISH with a preset result, or to SHIFT.
  - exp_field=0 and mant=0 (either sign): result 0, status 0001 -> FINISH.
  - e<0, other cases: result 0, status 0111 (underflow) -> FINISH.
  - e=31, sign=1, mant=0: result 0x80000000, status 0001 -> FINISH.
  - e>=31, other cases: saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative), status 0011 -> FINISH.
  - 0<=e<=24: load a 32-bit accumulator with sig, direction right, cnt = 25-e (1..25), sticky 0 -> SHIFT.
  - e=25: cnt=0 -> FINISH directly.
  - 26<=e<=30: direction left, cnt = e-25 (1..5) -> SHIFT.
- SHIFT:
  - Each edge shifts the accumulator one bit in the selected direction and decrements cnt.
  - Right shifts OR the bit shifted out into sticky.
  - Go to FINISH on the edge where cnt goes 1 -> 0.
  - Left shifts never lose bits, because e<=30 keeps the magnitude below 2^31.
- FINISH (one edge):
  - Non-special result: data_out = sign ? -acc : acc, truncated toward zero; status_out = sticky ? 1111 : 0001.
  - Special result: write the preset value and status.
  - done_out=1 for this one cycle only; state goes to IDLE, so ready_out=1 in the same cycle as done_out.
- Latency from the accept edge to the done_out cycle: 2 + cnt edges (cnt=0 for special cases and e=25).
  - Minimum 2 edges; maximum 27 edges (e=0).
- Back-to-back operation: start_in held high during the done cycle is accepted on the following edge.
- Arithmetic:
  - Accumulator is unsigned 32 bits; negation is two's complement on the 32-bit value.
  - Status encodings are exclusive; overflow takes priority over inexact.

Test Plan:
- Reset, then op_in=0x3E000000 (+1.0) with start_in pulse -> done after 27 edges; data_out=0x00000001, status_out=0001.
- op_in=0xBE000000 (-1.0) -> data_out=0xFFFFFFFF, status 0001. op_in=0x40800000 (+2.5) -> data_out=0x00000002, status 1111, latency 26.
- op_in=0x7A000000 (+2^30) -> data_out=0x40000000, status 0001, latency 7 (5 left shifts).
- Boundaries:
  - 0x7C000000 -> 0x7FFFFFFF, status 0011.
  - 0xFC000000 -> 0x80000000, status 0001.
  - 0x7E000000 -> 0x7FFFFFFF, status 0011.
  - 0x3C000000 (0.5) -> 0, status 0111.
  - 0x00000000 and 0x80000000 -> 0, status 0001.
  - Each of these has latency 2.
- Handshake:
  - start_in pulsed with a new operand while busy -> ignored; only the first result is produced and ready_out stays 0 until the done cycle.
  - start_in held high across done -> the second conversion starts on the next edge.
- Reset asserted during SHIFT for a +1.0 conversion -> immediately ready_out=1, data_out=0, status_out=0001; no done pulse.
